bullet_scheduler: RTL and testbench

//   Owns a fixed pool of bullet slots shared by the player ship and the enemy.

---
 rtl/bullet_scheduler.sv | 146 ++++++++++++++
 tb/tb_bullet_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_scheduler.sv
// Bullet slot pool: arbitrates player/enemy fire requests into free slots and moves live bullets.
// Optional FIRE_COOLDOWN_EN adds a per-owner cooldown (in move_ticks) between grants.
module bullet_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_PER_OWNER  = 2,
  parameter int Y_MAX          = 119,
  parameter int P_SPAWN_Y      = 110,
  parameter int E_SPAWN_Y      = 8,
  parameter int COOLDOWN_TICKS = 8,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 move_tick,
  input  logic                 p_fire,
  input  logic [7:0]           p_x,
  input  logic                 e_fire,
  input  logic [7:0]           e_x,
  input  logic                 hit_valid,
  input  logic [SW-1:0]        hit_slot,
  output logic                 p_fire_ack,
  output logic                 e_fire_ack,
  input  logic [SW-1:0]        rd_slot,
  output logic                 rd_active,
  output logic                 rd_owner,
  output logic [7:0]           rd_x,
  output logic [6:0]           rd_y,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 pool_full
);

  localparam int CW = $clog2(COOLDOWN_TICKS + 1);

  // Fire handshake: p_fire/e_fire are level requests; each grant is reported by a
  // one-cycle ack the cycle after the grant edge, and a request still held then counts as new.

  logic [NUM_SLOTS-1:0] active, owner, active_d, owner_d;
  logic [7:0]           x_q [NUM_SLOTS];
  logic [7:0]           x_d [NUM_SLOTS];
  logic [6:0]           y_q [NUM_SLOTS];
  logic [6:0]           y_d [NUM_SLOTS];
  logic                 ptr;  // 0: player wins a contested grant
  logic [CW-1:0]        p_cd, e_cd;
  logic [SW-1:0]        free_idx;
  logic                 has_free, p_elig, e_elig, grant_p, grant_e;
  int                   p_cnt, e_cnt;

  always_comb begin
    p_cnt    = 0;
    e_cnt    = 0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        has_free = 1'b1;
        free_idx = SW'(i);
      end else if (owner[i]) begin
        e_cnt = e_cnt + 1;
      end else begin
        p_cnt = p_cnt + 1;
      end
    end
  end

  assign p_elig  = p_fire && has_free && (p_cnt < MAX_PER_OWNER) && (p_cd == '0);
  assign e_elig  = e_fire && has_free && (e_cnt < MAX_PER_OWNER) && (e_cd == '0);
  assign grant_p = p_elig && (!e_elig || !ptr);
  assign grant_e = e_elig && (!p_elig || ptr);

  // Hits and moves only touch slots live before this edge, so a fresh allocation keeps its spawn row.
  always_comb begin
    active_d = active;
    owner_d  = owner;
    x_d      = x_q;
    y_d      = y_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (active[i]) begin
        if (hit_valid && hit_slot == SW'(i)) begin
          active_d[i] = 1'b0;
        end else if (move_tick) begin
          if (!owner[i]) begin
            if (y_q[i] == 7'd0) active_d[i] = 1'b0;
            else                y_d[i]      = y_q[i] - 7'd1;
          end else begin
            if (y_q[i] == 7'(Y_MAX)) active_d[i] = 1'b0;
            else                     y_d[i]      = y_q[i] + 7'd1;
          end
        end
      end
    end
    if (grant_p || grant_e) begin
      active_d[free_idx] = 1'b1;
      owner_d[free_idx]  = grant_e;
      x_d[free_idx]      = grant_e ? e_x : p_x;
      y_d[free_idx]      = grant_e ? 7'(E_SPAWN_Y) : 7'(P_SPAWN_Y);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      active     <= '0;
      owner      <= '0;
      ptr        <= 1'b0;
      p_fire_ack <= 1'b0;
      e_fire_ack <= 1'b0;
      pool_full  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= 8'd0;
        y_q[i] <= 7'd0;
      end
    end else begin
      active     <= active_d;
      owner      <= owner_d;
      x_q        <= x_d;
      y_q        <= y_d;
      p_fire_ack <= grant_p;
      e_fire_ack <= grant_e;
      pool_full  <= &active_d;
      if (p_elig && e_elig) ptr <= ~ptr;
    end
  end

`ifdef FIRE_COOLDOWN_EN
  always_ff @(posedge clock) begin
    if (!resetn) begin
      p_cd <= '0;
      e_cd <= '0;
    end else begin
      if (grant_p)                    p_cd <= CW'(COOLDOWN_TICKS);
      else if (move_tick && p_cd != '0) p_cd <= p_cd - CW'(1);
      if (grant_e)                    e_cd <= CW'(COOLDOWN_TICKS);
      else if (move_tick && e_cd != '0) e_cd <= e_cd - CW'(1);
    end
  end
`else
  assign p_cd = '0;
  assign e_cd = '0;
`endif

  assign active_mask = active;
  assign rd_active   = active[rd_slot];
  assign rd_owner    = owner[rd_slot];
  assign rd_x        = x_q[rd_slot];
  assign rd_y        = y_q[rd_slot];

endmodule

// File: tb/tb_bullet_scheduler.sv
// Bench for bullet_scheduler: directed scenarios plus random traffic against a slot-pool model.
module tb_bullet_scheduler;
  localparam int N = 4, MAXO = 2, YMAX = 119, PSY = 110, ESY = 8, COOL = 8;

  logic       clock = 0, resetn = 0, move_tick = 0, p_fire = 0, e_fire = 0, hit_valid = 0;
  logic [7:0] p_x = 0, e_x = 0;
  logic [1:0] hit_slot = 0, rd_slot = 0;
  logic       p_fire_ack, e_fire_ack, rd_active, rd_owner, pool_full;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [N-1:0] active_mask;

  int total = 0, bad = 0;
  bit check_en = 0;

  bullet_scheduler dut (
    .clock(clock), .resetn(resetn), .move_tick(move_tick),
    .p_fire(p_fire), .p_x(p_x), .e_fire(e_fire), .e_x(e_x),
    .hit_valid(hit_valid), .hit_slot(hit_slot),
    .p_fire_ack(p_fire_ack), .e_fire_ack(e_fire_ack),
    .rd_slot(rd_slot), .rd_active(rd_active), .rd_owner(rd_owner),
    .rd_x(rd_x), .rd_y(rd_y), .active_mask(active_mask), .pool_full(pool_full)
  );

  always #5 clock = ~clock;

  // Reference model: a list of slots updated once per rising edge from the spec's rules.
  bit m_act [N];
  bit m_own [N];
  int m_x [N];
  int m_y [N];
  bit m_ptr = 0, m_pack = 0, m_eack = 0;
  int m_pcd = 0, m_ecd = 0;

  always @(posedge clock) begin
    int pc, ec, fr;
    bit pe, ee, gp, ge;
    if (!resetn) begin
      for (int s = 0; s < N; s++) begin m_act[s] = 0; m_own[s] = 0; m_x[s] = 0; m_y[s] = 0; end
      m_ptr = 0; m_pack = 0; m_eack = 0; m_pcd = 0; m_ecd = 0;
    end else begin
      pc = 0; ec = 0; fr = -1;
      for (int s = 0; s < N; s++) begin
        if (m_act[s]) begin if (m_own[s]) ec++; else pc++; end
        else if (fr < 0) fr = s;
      end
      pe = p_fire && fr >= 0 && pc < MAXO && m_pcd == 0;
      ee = e_fire && fr >= 0 && ec < MAXO && m_ecd == 0;
      gp = pe && (!ee || !m_ptr);
      ge = ee && (!pe || m_ptr);
      if (pe && ee) m_ptr = !m_ptr;
      for (int s = 0; s < N; s++) begin
        if (m_act[s]) begin
          if (hit_valid && int'(hit_slot) == s) m_act[s] = 0;
          else if (move_tick) begin
            if (!m_own[s]) begin if (m_y[s] == 0) m_act[s] = 0; else m_y[s]--; end
            else begin if (m_y[s] == YMAX) m_act[s] = 0; else m_y[s]++; end
          end
        end
      end
      if (gp || ge) begin
        m_act[fr] = 1; m_own[fr] = ge;
        m_x[fr] = ge ? int'(e_x) : int'(p_x);
        m_y[fr] = ge ? ESY : PSY;
      end
`ifdef FIRE_COOLDOWN_EN
      if (gp) m_pcd = COOL; else if (move_tick && m_pcd > 0) m_pcd--;
      if (ge) m_ecd = COOL; else if (move_tick && m_ecd > 0) m_ecd--;
`endif
      m_pack = gp; m_eack = ge;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: registered outputs, then every slot through the read port.
  always @(negedge clock) begin
    if (check_en) begin
      logic [N-1:0] mm;
      bit full;
      full = 1;
      for (int s = 0; s < N; s++) begin mm[s] = m_act[s]; full &= m_act[s]; end
      chk("p_fire_ack", p_fire_ack, m_pack);
      chk("e_fire_ack", e_fire_ack, m_eack);
      chk("active_mask", active_mask, mm);
      chk("pool_full", pool_full, full);
      for (int s = 0; s < N; s++) begin
        rd_slot = s[1:0];
        #1;
        chk("rd_active", rd_active, m_act[s]);
        if (m_act[s]) begin
          chk("rd_owner", rd_owner, m_own[s]);
          chk("rd_x", rd_x, m_x[s]);
          chk("rd_y", rd_y, m_y[s]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    resetn = 0; p_fire = 0; e_fire = 0; move_tick = 0; hit_valid = 0;
    step();
    chk("rst_mask", active_mask, 0);
    chk("rst_pack", p_fire_ack, 0);
    chk("rst_eack", e_fire_ack, 0);
    chk("rst_full", pool_full, 0);
    resetn = 1;
  endtask

  initial begin
    int acks;
    do_reset();
    check_en = 1;

    // 1: single player shot
    p_fire = 1; p_x = 40;
    step();
    p_fire = 0;
    chk("t1_ack", p_fire_ack, 1);
    chk("t1_mask", active_mask, 4'b0001);
    chk("t1_model_x", m_x[0], 40);
    chk("t1_model_y", m_y[0], 110);
    chk("t1_model_own", m_own[0], 0);
    step();
    chk("t1_ack_drop", p_fire_ack, 0);

    // 2: contested request, player first then enemy
    do_reset();
    p_fire = 1; e_fire = 1; p_x = 10; e_x = 20;
    step();
    chk("t2_pack1", p_fire_ack, 1);
    chk("t2_eack1", e_fire_ack, 0);
    step();
    p_fire = 0; e_fire = 0;
    chk("t2_pack2", p_fire_ack, 0);
    chk("t2_eack2", e_fire_ack, 1);
    chk("t2_mask", active_mask, 4'b0011);
    chk("t2_model_own1", m_own[1], 1);
    step();
    chk("t2_acks_idle", {p_fire_ack, e_fire_ack}, 0);

    // 3: enemy bullet reaches the bottom edge
    do_reset();
    e_fire = 1; e_x = 5;
    step();
    e_fire = 0;
    move_tick = 1;
    for (int k = 0; k < 110; k++) step();
    chk("t3_model_y118", m_y[0], 118);
    step();
    chk("t3_model_y119", m_y[0], 119);
    chk("t3_mask_live", active_mask, 4'b0001);
    step();
    move_tick = 0;
    chk("t3_mask_gone", active_mask, 4'b0000);

`ifndef FIRE_COOLDOWN_EN
    // 4: per-owner limit, then a hit frees a slot
    do_reset();
    p_fire = 1; p_x = 60; acks = 0;
    for (int k = 0; k < 4; k++) begin step(); acks += p_fire_ack; end
    chk("t4_acks", acks, 2);
    chk("t4_mask", active_mask, 4'b0011);
    hit_valid = 1; hit_slot = 0;
    step();
    hit_valid = 0;
    chk("t4_no_ack_on_hit", p_fire_ack, 0);
    chk("t4_mask_hit", active_mask, 4'b0010);
    step();
    p_fire = 0;
    chk("t4_ack_after_hit", p_fire_ack, 1);
    chk("t4_mask_refill", active_mask, 4'b0011);

    // 5: hit and move in the same cycle
    e_fire = 1; e_x = 90;
    step();
    e_fire = 0;
    hit_valid = 1; hit_slot = 0; move_tick = 1;
    step();
    hit_valid = 0; move_tick = 0;
    chk("t5_mask", active_mask, 4'b0110);
    chk("t5_model_y1", m_y[1], 109);
    chk("t5_model_y2", m_y[2], 9);
`endif

    // 6: back-to-back grants with a held request
    do_reset();
    p_fire = 1; p_x = 77;
    step();
    chk("t6_ack1", p_fire_ack, 1);
`ifdef FIRE_COOLDOWN_EN
    acks = 0; move_tick = 1;
    for (int k = 0; k < COOL; k++) begin step(); acks += p_fire_ack; end
    move_tick = 0;
    chk("t6_no_ack_cool", acks, 0);
    step();
    chk("t6_ack2", p_fire_ack, 1);
`else
    step();
    chk("t6_ack2", p_fire_ack, 1);
`endif
    p_fire = 0;

    // Random traffic, checked every cycle by the compare process
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      resetn    = ($urandom_range(0, 199) != 0);
      p_fire    = $urandom_range(0, 1);
      e_fire    = $urandom_range(0, 1);
      p_x       = 8'($urandom_range(0, 255));
      e_x       = 8'($urandom_range(0, 255));
      move_tick = ($urandom_range(0, 9) < 3);
      hit_valid = ($urandom_range(0, 9) == 0);
      hit_slot  = 2'($urandom_range(0, 3));
      step();
    end
    resetn = 1; p_fire = 0; e_fire = 0; move_tick = 0; hit_valid = 0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
